// File: rtl/microsequencer.sv
// microsequencer
//
// Sequences the T-states of each instruction, forms the microcode ROM
// address from {opcode, tstate} and feeds the selected microinstruction to
// the control decoder. The decoder's RT encoding in the outgoing word ends
// the instruction early. A free-running 16-bit counter tracks retired
// instructions for bring-up and test.
//
// Build option:
//   USEQ_HARDWIRED_FETCH_EN - when defined, T0/T1 emit fixed fetch words and
//                             the ROM is only consulted from T2 onward. When
//                             undefined, every T-state comes from the ROM.
//
// There is no handshake on this block: the ROM is combinational and the
// decoder consumes one word per clock, so there is no valid/ready pair.
// The sequencing state (tstate) is visible on its own output port.

module microsequencer #(
  parameter logic [15:0] NOP_UINSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [7:0]  opcode,
  input  logic [15:0] urom_data,
  output logic [10:0] uaddr,
  output logic [15:0] uinstr,
  output logic [2:0]  tstate,
  output logic [15:0] instr_count
);

  // Fixed fetch words: PC out -> MAR in, then RAM out -> IR in with P+.
  localparam logic [15:0] FETCH_T0_UINSTR = 16'h8020;
  localparam logic [15:0] FETCH_T1_UINSTR = 16'hB440;

  localparam logic [2:0]  TSTATE_FIRST = 3'd0;
  localparam logic [2:0]  TSTATE_LAST  = 3'd7;

  logic [2:0]  tstate_q;
  logic [2:0]  tstate_d;
  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [15:0] uinstr_w;
  logic        rt;
  logic        retire;

  // ROM address is purely combinational; the opcode is not latched here.
  always_comb begin
    uaddr = {opcode, tstate_q};
  end

  // Microinstruction select: NOP while reset/halt, then fetch, then ROM.
  always_comb begin
    uinstr_w = urom_data;
    if (reset || halt) begin
      uinstr_w = NOP_UINSTR;
    end
`ifdef USEQ_HARDWIRED_FETCH_EN
    else if (tstate_q == 3'd0) begin
      uinstr_w = FETCH_T0_UINSTR;
    end
    else if (tstate_q == 3'd1) begin
      uinstr_w = FETCH_T1_UINSTR;
    end
`endif
  end

  // RT decode is taken after the mux so NOP or fetch words never restart.
  always_comb begin
    rt = uinstr_w[15] & uinstr_w[11];
  end

  // Next-state: reset beats halt, halt freezes, RT or T7 retires.
  always_comb begin
    tstate_d = tstate_q;
    count_d  = count_q;
    retire   = 1'b0;
    if (reset) begin
      tstate_d = TSTATE_FIRST;
      count_d  = '0;
    end
    else if (halt) begin
      tstate_d = tstate_q;
      count_d  = count_q;
    end
    else if (rt || (tstate_q == TSTATE_LAST)) begin
      // An RT at T0 is a microcode bug but is allowed to retire anyway.
      retire   = 1'b1;
      tstate_d = TSTATE_FIRST;
      count_d  = count_q + 16'd1;  // wraps silently at 16'hFFFF
    end
    else begin
      tstate_d = tstate_q + 3'd1;
    end
  end

  // State register; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    if (reset) begin
      tstate_q <= TSTATE_FIRST;
      count_q  <= '0;
    end
    else begin
      tstate_q <= tstate_d;
      count_q  <= count_d;
    end
  end

  // Output drive.
  always_comb begin
    uinstr      = uinstr_w;
    tstate      = tstate_q;
    instr_count = count_q;
  end

  // retire is kept as a named event for probing; fold it into nothing else.
  logic retire_unused;
  always_comb begin
    retire_unused = retire;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: reset, full sequence, RT restart,
// fetch selection, halt, reset mid-instruction and counter wrap.

module tb_microsequencer;

  logic        clk;
  logic        reset;
  logic        halt;
  logic [7:0]  opcode;
  logic [15:0] urom_data;
  logic [10:0] uaddr;
  logic [15:0] uinstr;
  logic [2:0]  tstate;
  logic [15:0] instr_count;

  int n_cmp;
  int n_err;
  logic [15:0] exp_count;

  microsequencer #(.NOP_UINSTR(16'hF000)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .opcode      (opcode),
    .urom_data   (urom_data),
    .uaddr       (uaddr),
    .uinstr      (uinstr),
    .tstate      (tstate),
    .instr_count (instr_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected word at a T-state for a given ROM value.
  function automatic logic [15:0] exp_word(input logic [2:0] t, input logic [15:0] rom);
`ifdef USEQ_HARDWIRED_FETCH_EN
    if (t == 3'd0) return 16'h8020;
    if (t == 3'd1) return 16'hB440;
`endif
    return rom;
  endfunction

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; opcode = 8'h00; urom_data = 16'h0000;
    #1;
    n_cmp++;
    if (uinstr !== 16'hF000) begin
      n_err++; $display("FAIL reset_uinstr_pre: got %h want f000", uinstr);
    end
    step(); step();
    n_cmp++;
    if (uinstr !== 16'hF000) begin
      n_err++; $display("FAIL reset_uinstr: got %h want f000", uinstr);
    end
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL reset_tstate: got %0d want 0", tstate);
    end
    n_cmp++;
    if (instr_count !== 16'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", instr_count);
    end
    n_cmp++;
    if (uaddr !== 11'h000) begin
      n_err++; $display("FAIL reset_uaddr: got %h want 000", uaddr);
    end
    reset = 1'b0;
    exp_count = 16'd0;
    #1;
  endtask

  task automatic test_sequence();
    logic [10:0] ea;
    opcode = 8'h00; urom_data = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      ea = {8'h00, 3'(i)};
      n_cmp++;
      if (tstate !== 3'(i)) begin
        n_err++; $display("FAIL seq_tstate[%0d]: got %0d want %0d", i, tstate, i);
      end
      n_cmp++;
      if (uaddr !== ea) begin
        n_err++; $display("FAIL seq_uaddr[%0d]: got %h want %h", i, uaddr, ea);
      end
      n_cmp++;
      if (uinstr !== exp_word(3'(i), 16'h0000)) begin
        n_err++; $display("FAIL seq_uinstr[%0d]: got %h want %h", i, uinstr,
                          exp_word(3'(i), 16'h0000));
      end
      step();
    end
    exp_count = 16'd1;
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL seq_wrap_tstate: got %0d want 0", tstate);
    end
    n_cmp++;
    if (instr_count !== exp_count) begin
      n_err++; $display("FAIL seq_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_rt();
    opcode = 8'h5A; urom_data = 16'h0000;
    step(); step(); step();
    urom_data = 16'h8800;
    #1;
    n_cmp++;
    if (tstate !== 3'd3) begin
      n_err++; $display("FAIL rt_at_t3: got %0d want 3", tstate);
    end
    n_cmp++;
    if (uaddr !== 11'h2D3) begin
      n_err++; $display("FAIL rt_uaddr: got %h want 2d3", uaddr);
    end
    n_cmp++;
    if (uinstr !== 16'h8800) begin
      n_err++; $display("FAIL rt_uinstr: got %h want 8800", uinstr);
    end
    step();
    urom_data = 16'h0000;
    exp_count = exp_count + 16'd1;
    #1;
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL rt_restart: got %0d want 0", tstate);
    end
    n_cmp++;
    if (instr_count !== exp_count) begin
      n_err++; $display("FAIL rt_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_fetch();
    opcode = 8'h12;
    for (int i = 0; i < 8; i++) begin
      urom_data = 16'hFFFF;
      #1;
      n_cmp++;
      if (uinstr !== exp_word(3'(i), 16'hFFFF)) begin
        n_err++; $display("FAIL fetch_uinstr[%0d]: got %h want %h", i, uinstr,
                          exp_word(3'(i), 16'hFFFF));
      end
      // Park the ROM on a non-RT word so the edge just advances.
      urom_data = 16'h0000;
      step();
    end
    exp_count = exp_count + 16'd1;
    n_cmp++;
    if (instr_count !== exp_count) begin
      n_err++; $display("FAIL fetch_count: got %0d want %0d", instr_count, exp_count);
    end
  endtask

  task automatic test_halt();
    opcode = 8'h33; urom_data = 16'h0000;
    step(); step(); step(); step();
    halt = 1'b1; urom_data = 16'h8800;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (uinstr !== 16'hF000) begin
        n_err++; $display("FAIL halt_uinstr[%0d]: got %h want f000", i, uinstr);
      end
      n_cmp++;
      if (tstate !== 3'd4) begin
        n_err++; $display("FAIL halt_tstate[%0d]: got %0d want 4", i, tstate);
      end
      step();
    end
    halt = 1'b0; urom_data = 16'h0000;
    #1;
    n_cmp++;
    if (tstate !== 3'd4) begin
      n_err++; $display("FAIL halt_release_tstate: got %0d want 4", tstate);
    end
    n_cmp++;
    if (instr_count !== exp_count) begin
      n_err++; $display("FAIL halt_count: got %0d want %0d", instr_count, exp_count);
    end
    step();
    n_cmp++;
    if (tstate !== 3'd5) begin
      n_err++; $display("FAIL halt_resume: got %0d want 5", tstate);
    end
  endtask

  task automatic test_reset_mid();
    urom_data = 16'h8800;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (uinstr !== 16'hF000) begin
      n_err++; $display("FAIL rstmid_uinstr: got %h want f000", uinstr);
    end
    step();
    reset = 1'b0; urom_data = 16'h0000;
    exp_count = 16'd0;
    #1;
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL rstmid_tstate: got %0d want 0", tstate);
    end
    n_cmp++;
    if (instr_count !== 16'd0) begin
      n_err++; $display("FAIL rstmid_count: got %0d want 0", instr_count);
    end
  endtask

  task automatic test_wrap();
    opcode = 8'hC0;
    urom_data = 16'h8800;
`ifdef USEQ_HARDWIRED_FETCH_EN
    // RT only reachable at T2: three cycles per instruction.
    for (int i = 0; i < 12; i++) step();
    n_cmp++;
    if (instr_count !== 16'd4) begin
      n_err++; $display("FAIL wrap_short_count: got %0d want 4", instr_count);
    end
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL wrap_short_tstate: got %0d want 0", tstate);
    end
`else
    // RT at T0 retires one instruction per cycle.
    for (int i = 0; i < 65535; i++) step();
    n_cmp++;
    if (instr_count !== 16'hFFFF) begin
      n_err++; $display("FAIL wrap_pre: got %h want ffff", instr_count);
    end
    n_cmp++;
    if (tstate !== 3'd0) begin
      n_err++; $display("FAIL wrap_tstate: got %0d want 0", tstate);
    end
    step();
    n_cmp++;
    if (instr_count !== 16'h0000) begin
      n_err++; $display("FAIL wrap_zero: got %h want 0000", instr_count);
    end
`endif
    urom_data = 16'h0000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_count = 16'd0;
    reset = 1'b1; halt = 1'b0; opcode = 8'h00; urom_data = 16'h0000;
    test_reset();
    test_sequence();
    test_rt();
    test_fetch();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
